// File: rtl/colocador_barcos_if.sv
// Request/status bundle for the ship placer: the master drives the placement
// request and observes the board, the slave is the placer itself.
interface colocador_barcos_if;
    logic [4:0]  cell_idx;
    logic        orient;
    logic        place;
    logic [24:0] board;
    logic [2:0]  ship_num;
    logic        busy;
    logic        placed;
    logic        reject;
    logic        done;

    modport master (
        output cell_idx, orient, place,
        input  board, ship_num, busy, placed, reject, done
    );

    modport slave (
        input  cell_idx, orient, place,
        output board, ship_num, busy, placed, reject, done
    );
endinterface

// File: rtl/colocador_barcos.sv
// Places NUM_SHIPS ships (ship k has length k+1) on a 5x5 board one request at a time.
// Optional macro ADJ_GAP_EN also refuses ships touching an existing ship orthogonally.
module colocador_barcos #(
    parameter int NUM_SHIPS = 3
) (
    input  logic            clk,
    input  logic            rst,
    colocador_barcos_if.slave bus
);

    typedef enum logic [2:0] {IDLE, CHECK, WRITE, REJECT, DONE} state_t;

    // Bits sitting in column 0 and column 4 of the row-major board.
    localparam logic [24:0] COL_FIRST = 25'h0108421;
    localparam logic [24:0] COL_LAST  = 25'h1084210;

    state_t      state, state_next;
    logic [4:0]  req_idx;
    logic        req_orient;
    logic [24:0] board_q;
    logic [2:0]  ship_q;

    logic [4:0]  base;
    logic [2:0]  row, col, start, len;
    logic        in_range, fits, req_ok;
    logic [24:0] target, blocked;
    int          pos;

    // Target mask and validity are derived from the captured request; board and
    // ship count do not move between CHECK and WRITE, so WRITE reuses the mask.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        base     = req_idx - 5'd1;
        row      = 3'(base / 5'd5);
        col      = 3'(base % 5'd5);
        len      = ship_q + 3'd1;
        start    = req_orient ? row : col;
        in_range = (req_idx != 5'd0) && (req_idx <= 5'd25);
        fits     = ({1'b0, start} + {1'b0, len}) <= 4'd5;
        target   = '0;
        pos      = 0;
        for (int k = 0; k < 5; k++) begin
            if (k < int'(len)) begin
                pos = int'(base) + (req_orient ? 5 * k : k);
                if (pos < 25) target = target | (25'd1 << pos);
            end
        end
`ifdef ADJ_GAP_EN
        blocked = board_q
                | ((board_q << 1) & ~COL_FIRST)
                | ((board_q >> 1) & ~COL_LAST)
                | (board_q << 5)
                | (board_q >> 5);
`else
        blocked = board_q;
`endif
        req_ok = in_range && fits && ((target & blocked) == 25'd0);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.place) state_next = CHECK;
            CHECK:   state_next = req_ok ? WRITE : REJECT;
            WRITE:   state_next = (ship_q + 3'd1 == 3'(NUM_SHIPS)) ? DONE : IDLE;
            REJECT:  state_next = IDLE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_idx    <= '0;
            req_orient <= 1'b0;
            board_q    <= '0;
            ship_q     <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && bus.place) begin
                req_idx    <= bus.cell_idx;
                req_orient <= bus.orient;
            end
            if (state == WRITE) begin
                board_q <= board_q | target;
                ship_q  <= ship_q + 3'd1;
            end
        end
    end

    assign bus.board    = board_q;
    assign bus.ship_num = ship_q;
    assign bus.busy     = (state == CHECK) || (state == WRITE) || (state == REJECT);
    assign bus.placed   = (state == WRITE);
    assign bus.reject   = (state == REJECT);
    assign bus.done     = (state == DONE);

endmodule

// File: tb/tb_colocador_barcos.sv
// Scoreboard bench for colocador_barcos: a grid-level model predicts each
// request's outcome, a separate monitor pops predictions on placed/reject pulses.
module tb_colocador_barcos;

    localparam int NUM_SHIPS = 3;

    typedef struct {
        bit          ok;
        logic [24:0] board;
        logic [2:0]  ship_num;
        bit          done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    colocador_barcos_if bus ();

    colocador_barcos #(.NUM_SHIPS(NUM_SHIPS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    bit   occ[5][5];
    int   m_ship;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // ---------------- reference model on a 5x5 grid ----------------
    function automatic bit occupied(input int r, input int c);
        if (r < 0 || r > 4 || c < 0 || c > 4) return 1'b0;
        return occ[r][c];
    endfunction

    function automatic bit model_ok(input int idx, input bit ori);
        int r0, c0, r, c;
        if (idx < 1 || idx > 25) return 1'b0;
        r0 = (idx - 1) / 5;
        c0 = (idx - 1) % 5;
        for (int k = 0; k <= m_ship; k++) begin
            r = r0 + (ori ? k : 0);
            c = c0 + (ori ? 0 : k);
            if (r > 4 || c > 4) return 1'b0;
            if (occ[r][c]) return 1'b0;
`ifdef ADJ_GAP_EN
            if (occupied(r - 1, c) || occupied(r + 1, c) ||
                occupied(r, c - 1) || occupied(r, c + 1)) return 1'b0;
`endif
        end
        return 1'b1;
    endfunction

    function automatic logic [24:0] model_board();
        logic [24:0] b = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                if (occ[r][c]) b[r*5+c] = 1'b1;
        return b;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                occ[r][c] = 1'b0;
        m_ship = 0;
    endtask

    task automatic model_place(input int idx, input bit ori);
        int r0 = (idx - 1) / 5;
        int c0 = (idx - 1) % 5;
        for (int k = 0; k <= m_ship; k++)
            occ[r0 + (ori ? k : 0)][c0 + (ori ? 0 : k)] = 1'b1;
        m_ship++;
    endtask

    // ---------------- driver ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.place = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check("rst_board",  32'(bus.board), 32'h0);
        check("rst_ship",   32'(bus.ship_num), 32'h0);
        check("rst_flags",  32'({bus.busy, bus.placed, bus.reject, bus.done}), 32'h0);
    endtask

    // Holds place high through the whole busy window; scrambles cell_idx/orient
    // after capture to show the request is latched at E0.
    task automatic issue(input logic [4:0] idx, input bit ori);
        exp_t e;
        bit   active = (m_ship < NUM_SHIPS);
        if (active) begin
            e.ok = model_ok(int'(idx), ori);
            if (e.ok) model_place(int'(idx), ori);
            e.board    = model_board();
            e.ship_num = 3'(m_ship);
            e.done     = (m_ship == NUM_SHIPS);
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.cell_idx = idx;
        bus.orient   = ori;
        bus.place    = 1'b1;
        @(negedge clk);
        check("busy_in_check", 32'(bus.busy), 32'(active));
        bus.cell_idx = 5'($urandom);
        bus.orient   = 1'($urandom);
        @(negedge clk);
        check("pulse_latency", 32'(bus.placed | bus.reject), 32'(active));
        @(negedge clk);
        bus.place = 1'b0;
        check("idle_after", 32'(bus.busy), 32'h0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (bus.placed || bus.reject)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'({bus.placed, bus.reject}), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", 32'({bus.placed, bus.reject}), e.ok ? 32'h2 : 32'h1);
                    @(negedge clk);
                    check("board_after", 32'(bus.board), 32'(e.board));
                    check("ship_after",  32'(bus.ship_num), 32'(e.ship_num));
                    check("done_after",  32'(bus.done), 32'(e.done));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.cell_idx = '0;
        bus.orient   = 1'b0;
        bus.place    = 1'b0;
        model_clear();
        do_reset();

        // Bounds rejects on an empty board.
        issue(5'd0, 1'b0);
        issue(5'd26, 1'b0);
        check("oob_board", 32'(bus.board), 32'h0);

        // Directed placement walk.
        issue(5'd1, 1'b0);
        check("d1_board", 32'(bus.board), 32'h0000001);
        issue(5'd5, 1'b0);
        check("d2_board", 32'(bus.board), 32'h0000001);
        issue(5'd5, 1'b1);
        check("d3_board", 32'(bus.board), 32'h0000211);
        issue(5'd8, 1'b0);
        check("d4_board", 32'(bus.board), 32'h0000211);
        issue(5'd21, 1'b0);
        check("d5_board", 32'(bus.board), 32'h0700211);
        check("d5_ship",  32'(bus.ship_num), 32'h3);
        check("d5_done",  32'(bus.done), 32'h1);
        issue(5'd13, 1'b0);
        issue(5'd2, 1'b1);
        check("done_frozen", 32'(bus.board), 32'h0700211);
        check("done_held",   32'(bus.done), 32'h1);

        // Reset while CHECK is evaluating a valid request.
        do_reset();
        @(negedge clk);
        bus.cell_idx = 5'd1;
        bus.orient   = 1'b0;
        bus.place    = 1'b1;
        @(negedge clk);
        check("mid_busy", 32'(bus.busy), 32'h1);
        rst       = 1'b1;
        bus.place = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check("mid_rst_board", 32'(bus.board), 32'h0);
        check("mid_rst_flags", 32'({bus.busy, bus.placed, bus.reject, bus.ship_num}), 32'h0);
        @(negedge clk);
        check("mid_rst_quiet", 32'({bus.busy, bus.placed, bus.reject}), 32'h0);

        // Touching ships.
        issue(5'd1, 1'b0);
        issue(5'd2, 1'b0);
`ifdef ADJ_GAP_EN
        check("adj_board", 32'(bus.board), 32'h0000001);
`else
        check("adj_board", 32'(bus.board), 32'h0000007);
`endif

        // Randomized rounds.
        for (int round = 0; round < 6; round++) begin
            do_reset();
            for (int n = 0; n < 14; n++)
                issue(5'($urandom_range(0, 27)), 1'($urandom));
        end

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/colocador_barcos.md
COLOCADOR_BARCOS -- requirements
Module: colocador_barcos

Interface
REQ-001 Parameter NUM_SHIPS, default 3, legal 1..5: number of ships to place; ship k (0-based) has length k+1.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cell_idx  input  5  selected cell from the cell counter, linear 1..25, row-major on a 5x5 board.
REQ-005 orient  input  1  0 = horizontal (increasing column), 1 = vertical (increasing row).
REQ-006 place  input  1  placement request; level-sampled in IDLE only.
REQ-007 board  output  25  occupancy; bit i set = cell i+1 holds a ship.
REQ-008 ship_num  output  3  index of the next ship to place, 0..NUM_SHIPS.
REQ-009 busy  output  1  high in CHECK, WRITE and REJECT.
REQ-010 placed  output  1  one-cycle pulse, placement accepted.
REQ-011 reject  output  1  one-cycle pulse, placement refused.
REQ-012 done  output  1  high once all NUM_SHIPS ships are placed.

Function
REQ-013 FSM states SHALL be IDLE, CHECK, WRITE, REJECT, DONE; placed = (state==WRITE), reject = (state==REJECT), done = (state==DONE), all Moore.
REQ-014 IDLE with place=1 at edge E0 SHALL capture cell_idx and orient, then enter CHECK; place in any other state SHALL be ignored and not queued.
REQ-015 CHECK SHALL enter WRITE at edge E1 if the request is valid, else REJECT.
REQ-016 Row = (cell_idx-1)/5, col = (cell_idx-1)%5; length L = ship_num+1.
REQ-017 Invalid SHALL mean cell_idx==0, cell_idx>25, horizontal with col+L-1>4, vertical with row+L-1>4, or any target cell already set in board.
REQ-018 Horizontal target cells: cell_idx..cell_idx+L-1; vertical: cell_idx+5k for k=0..L-1; no wrap across row or board edges.
REQ-019 WRITE SHALL, at edge E2, OR the target mask into board, increment ship_num, and enter DONE if the new ship_num==NUM_SHIPS, else IDLE.
REQ-020 REJECT SHALL return to IDLE at edge E2 with board and ship_num unchanged.
REQ-021 Latency: placed/reject high during the cycle between E1 and E2; new board visible after E2.
REQ-022 DONE SHALL be held until rst; board frozen.
REQ-023 board bits SHALL change only in WRITE; no bit is ever cleared except by rst.

Reset
REQ-024 rst SHALL take priority over all other inputs, in any state including mid-CHECK/WRITE.
REQ-025 After rst: state IDLE, board=0, ship_num=0, busy=0, placed=0, reject=0, done=0; captured request discarded.

Configuration
REQ-026 Macro ADJ_GAP_EN: when defined, a request SHALL also be invalid if any target cell is orthogonally adjacent (same row col±1, or same col row±1) to a set board bit; when undefined, only overlap and bounds are checked.

Verification
REQ-027 rst, then place=1, idx=1, orient=0 -> placed pulse 2 cycles later, board=25'h0000001, ship_num=1.
REQ-028 Then idx=5, orient=0 (len 2, col 4) -> reject pulse, board=25'h0000001, ship_num=1; then idx=5, orient=1 -> placed, board=25'h0000211, ship_num=2.
REQ-029 Then idx=8, orient=0 (cells 8-10, overlaps 10) -> reject; then idx=21, orient=0 -> placed, board=25'h0700211, ship_num=3, done=1; further place pulses -> no placed/reject, board unchanged.
REQ-030 idx=0 and idx=26 -> reject each, board unchanged; place held high during busy -> exactly one placed or reject per IDLE entry.
REQ-031 rst asserted in CHECK after a valid request -> no placed pulse, board=0, ship_num=0, state IDLE next cycle.
REQ-032 Ship 0 at idx=1, then ship 1 horizontal at idx=2: with ADJ_GAP_EN -> reject; without -> placed, board=25'h0000007.
